traffic_intersection: RTL and testbench
=======================================

# traffic_intersection

Parametrised N-approach intersection controller. It replaces the per-direction light modules with one FSM that owns every approach, so only one approach can ever hold a non-red aspect. Approaches are served round-robin with an all-red clearance between them. The emergency request drives every approach through yellow to all-stop, then resumes at the next approach in rotation.

## Interface
- N_APPR, 2: number of approaches, 2..8.
- START_APPR, 0: approach served first after reset.
- T_LEFT, 5: left-arrow phase length in cycles, ≥1.
- T_GREEN, 10: green phase length in cycles, ≥1.
- T_YELLOW, 3: yellow phase length in cycles, ≥1.
- T_CLEAR, 1: all-red clearance length in cycles, ≥1.
- T_EMERG_MIN, 4: minimum all-stop hold in cycles, ≥1.
- CW, 5: counter width; must hold max(T_*)-1.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- emergency  in  1  all-stop request, sampled at posedge clk.
- out  out  4*N_APPR  per-approach lights. Approach i uses bits [4i+3:4i], encoded {left, green, yellow, red}.
- active  out  $clog2(N_APPR) (min 1)  approach currently served.
- allstop  out  1  high while in ALLSTOP.

## Operation
- Light codes: LEFT=4'b1001, GREEN=4'b0100, YELLOW=4'b0010, RED=4'b0001. Every non-active approach shows RED.
- States and transitions:
  - LEFT → GREEN.
  - GREEN → YELLOW.
  - YELLOW → CLEAR.
  - CLEAR → LEFT, with active advanced as (active+1) mod N_APPR.
  - EYEL → ALLSTOP.
  - ALLSTOP → CLEAR. This is the resume path; the next CLEAR→LEFT advances active.
- Phase length: each timed state lasts exactly T_x cycles. The counter runs 0..T_x-1 and clears on every state change.
- Emergency entry, checked at each posedge with emergency=1:
  - LEFT or GREEN → EYEL: active approach shows YELLOW for T_YELLOW cycles.
  - YELLOW → finishes its remaining count, then goes to ALLSTOP instead of CLEAR.
  - CLEAR → ALLSTOP immediately.
- Emergency latching: the request is held internally (emerg_pend). A one-cycle pulse completes the full sequence through ALLSTOP.
- ALLSTOP: all approaches RED, allstop=1. Exits to CLEAR once the counter reaches T_EMERG_MIN-1 and emergency=0. While emergency stays high, the counter saturates and the state holds.
- Emergency asserted again during the post-ALLSTOP CLEAR → ALLSTOP directly. The minimum hold restarts.
- Invalid or unused state encodings → CLEAR, same approach.

## Timing
- Reset values:
  - state = LEFT (GREEN with TL_LEFT_TURN_EN undefined), counter = 0, active = START_APPR, emerg_pend = 0, allstop = 0.
  - out = approach START_APPR at 1001 (or 0100 without the macro), all others 0001.
- out, active and allstop decode only from registers. There is no combinational path from emergency.
- Emergency latency: request high before edge k → at edge k the state changes (or emerg_pend is set in YELLOW) and out reflects it in the same cycle. Latency is one edge.
- Default rotation period: 19 cycles per approach (5+10+3+1), 38 for N_APPR=2.
- rst_n low mid-phase: all registers return to reset values immediately, with no clock needed. The first phase after release is a full-length phase.

## Configuration
- TL_LEFT_TURN_EN:
  - Defined: LEFT phase present as specified.
  - Undefined: LEFT state and T_LEFT are unused, and CLEAR → GREEN. Emergency entry from GREEN is unchanged.

## Structure
- Shared package tl_pkg holds:
  - state typedef: LEFT, GREEN, YELLOW, CLEAR, EYEL, ALLSTOP.
  - 4-bit light code constants.
- Sub-module tl_phase_timer:
  - Inputs: clear, load length, saturate.
  - Output: done, high when count == length-1.
  - The controller instantiates one.

## Test plan
- Reset, defaults, no emergency → approach 0 shows 1001 for 5 cycles, 0100 for 10, 0010 for 3, then all 0001 for 1. Approach 1 then shows 1001 at cycle 19 and active=1. Rotation returns to approach 0 at cycle 38.
- One-cycle emergency pulse at GREEN cycle 4 → next edge shows 0010 for 3 cycles, then ALLSTOP for exactly 4 cycles, then CLEAR for 1 cycle, then approach 1 LEFT.
- Emergency held 20 cycles starting in YELLOW count 1 → yellow finishes its remaining 1 cycle, allstop=1 until 1 edge after emergency falls, then CLEAR, then the next approach.
- Emergency during CLEAR, and again during the post-ALLSTOP CLEAR → immediate ALLSTOP both times. At no cycle are two approaches non-red.
- rst_n pulsed low at GREEN count 7 → out returns to reset pattern asynchronously and a full 5-cycle LEFT follows.
- N_APPR=4, START_APPR=2, macro undefined → order 2,3,0,1. No 1xxx code ever appears. Period is 14 cycles per approach.

Source files
------------

// File: rtl/tl_pkg.sv
// tl_pkg: shared types and constants for the traffic intersection controller.
//   tl_state_e   controller phase encoding (also exported on the debug port)
//   LIGHT_*      4-bit per-approach light codes, packed {left, green, yellow, red}
//   active_light served approach's light code for a given phase
// Optional feature macro used by the controller: TL_LEFT_TURN_EN.
package tl_pkg;

  typedef enum logic [2:0] {
    LEFT    = 3'd0,
    GREEN   = 3'd1,
    YELLOW  = 3'd2,
    CLEAR   = 3'd3,
    EYEL    = 3'd4,
    ALLSTOP = 3'd5
  } tl_state_e;

  localparam logic [3:0] LIGHT_LEFT   = 4'b1001;
  localparam logic [3:0] LIGHT_GREEN  = 4'b0100;
  localparam logic [3:0] LIGHT_YELLOW = 4'b0010;
  localparam logic [3:0] LIGHT_RED    = 4'b0001;

  // Light shown by the served approach. CLEAR and ALLSTOP keep every approach red.
  function automatic logic [3:0] active_light(input tl_state_e s);
    logic [3:0] code;
    case (s)
      LEFT:         code = LIGHT_LEFT;
      GREEN:        code = LIGHT_GREEN;
      YELLOW, EYEL: code = LIGHT_YELLOW;
      default:      code = LIGHT_RED;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// tl_phase_timer: phase-length counter for the intersection controller.
//   clk, rst_n  clock, asynchronous active-low reset
//   clear_i     restart the count at 0 on the next edge (phase change)
//   last_i      phase length minus one; taking length-1 lets a phase of
//               length 2**CW fit in a CW-bit counter
//   sat_i       hold at last_i instead of wrapping
//   done_o      high while count == last_i (final cycle of the phase)
module tl_phase_timer #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic [CW-1:0] last_i,
  input  logic          sat_i,
  output logic          done_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign done_o = (count_q == last_i);

  always_comb begin
    count_d = count_q + CW'(1);
    if (clear_i) begin
      count_d = '0;
    end else if (done_o) begin
      count_d = sat_i ? count_q : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/traffic_intersection.sv
// traffic_intersection: single FSM serving N_APPR approaches round-robin,
// with an all-red clearance between approaches and an emergency all-stop.
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   emergency  all-stop request, sampled at posedge clk
//   out        per-approach lights, approach i on [4i+3:4i], {left,green,yellow,red}
//   active     approach currently served
//   allstop    high while in ALLSTOP
//   state_dbg  current controller phase (for checkers)
// Macro TL_LEFT_TURN_EN: when defined each service starts with a LEFT phase;
// when undefined service starts at GREEN and T_LEFT is not used.
// Handshake: none; emergency is a level request. A single-cycle pulse is
// enough, since every entry path ends in ALLSTOP without needing it again.
module traffic_intersection
  import tl_pkg::*;
#(
  parameter int N_APPR      = 2,
  parameter int START_APPR  = 0,
  parameter int T_LEFT      = 5,
  parameter int T_GREEN     = 10,
  parameter int T_YELLOW    = 3,
  parameter int T_CLEAR     = 1,
  parameter int T_EMERG_MIN = 4,
  parameter int CW          = 5,
  localparam int AW         = (N_APPR > 1) ? $clog2(N_APPR) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  emergency,
  output logic [4*N_APPR-1:0]   out,
  output logic [AW-1:0]         active,
  output logic                  allstop,
  output tl_state_e             state_dbg
);

`ifdef TL_LEFT_TURN_EN
  localparam tl_state_e FIRST_PHASE = LEFT;
`else
  localparam tl_state_e FIRST_PHASE = GREEN;
`endif

  tl_state_e     state_q, state_d;
  logic [AW-1:0] active_q, active_d;
  logic          emerg_pend_q, emerg_pend_d;

  logic [CW-1:0] last;
  logic          done;
  logic          timer_clear;

  // Length of the phase currently running (minus one).
  always_comb begin
    case (state_q)
      LEFT:         last = CW'(T_LEFT - 1);
      GREEN:        last = CW'(T_GREEN - 1);
      YELLOW, EYEL: last = CW'(T_YELLOW - 1);
      CLEAR:        last = CW'(T_CLEAR - 1);
      ALLSTOP:      last = CW'(T_EMERG_MIN - 1);
      default:      last = '0;
    endcase
  end

  // Every phase change restarts the count from 0.
  assign timer_clear = (state_d != state_q);

  tl_phase_timer #(
    .CW (CW)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (timer_clear),
    .last_i  (last),
    .sat_i   (state_q == ALLSTOP),
    .done_o  (done)
  );

  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    emerg_pend_d = 1'b0;
    case (state_q)
`ifdef TL_LEFT_TURN_EN
      LEFT: begin
        if (emergency)  state_d = EYEL;
        else if (done)  state_d = GREEN;
      end
`endif
      GREEN: begin
        if (emergency)  state_d = EYEL;
        else if (done)  state_d = YELLOW;
      end
      YELLOW: begin
        // Yellow is already the stopping aspect: let it run out, but remember
        // any request seen along the way so it ends in ALLSTOP.
        if (done) begin
          state_d = (emergency || emerg_pend_q) ? ALLSTOP : CLEAR;
        end else begin
          emerg_pend_d = emerg_pend_q | emergency;
        end
      end
      CLEAR: begin
        if (emergency) begin
          state_d = ALLSTOP;
        end else if (done) begin
          state_d  = FIRST_PHASE;
          active_d = (active_q == AW'(N_APPR - 1)) ? '0 : active_q + AW'(1);
        end
      end
      EYEL: begin
        if (done) state_d = ALLSTOP;
      end
      ALLSTOP: begin
        // The timer saturates here, so done stays high once the minimum
        // hold has elapsed and release waits only on emergency.
        if (done && !emergency) state_d = CLEAR;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FIRST_PHASE;
      active_q     <= AW'(START_APPR);
      emerg_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      emerg_pend_q <= emerg_pend_d;
    end
  end

  // Outputs decode from registers only.
  always_comb begin
    out = '0;
    for (int i = 0; i < N_APPR; i++) begin
      out[4*i +: 4] = (active_q == AW'(i)) ? active_light(state_q) : LIGHT_RED;
    end
  end

  assign active    = active_q;
  assign allstop   = (state_q == ALLSTOP);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_traffic_intersection.sv
// tb_traffic_intersection: directed, table-driven bench for traffic_intersection.
// Two instances share clock, reset and emergency: a default 2-approach one and
// a 4-approach one starting at approach 2. Each table row holds the emergency
// level driven during a cycle and the outputs expected in that cycle.
module tb_traffic_intersection;
  import tl_pkg::*;

`ifdef TL_LEFT_TURN_EN
  localparam int         T_L     = 5;
  localparam logic [3:0] C_FIRST = 4'b1001;
`else
  localparam int         T_L     = 0;
  localparam logic [3:0] C_FIRST = 4'b0100;
`endif
  localparam logic [3:0] C_LEFT   = 4'b1001;
  localparam logic [3:0] C_GREEN  = 4'b0100;
  localparam logic [3:0] C_YELLOW = 4'b0010;
  localparam logic [3:0] C_RED    = 4'b0001;

  typedef struct {
    logic        em;
    logic [15:0] out;
    logic [2:0]  act;
    logic        as;
  } vec_t;

  vec_t tbl[$];

  logic       clk;
  logic       rst_n;
  logic       emergency;
  logic [7:0] out1;
  logic [0:0] act1;
  logic       as1;
  tl_state_e  dbg1;
  logic [15:0] out2;
  logic [1:0]  act2;
  logic        as2;
  tl_state_e   dbg2;

  int n_checks = 0;
  int n_err    = 0;

  traffic_intersection dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .emergency (emergency),
    .out       (out1),
    .active    (act1),
    .allstop   (as1),
    .state_dbg (dbg1)
  );

  traffic_intersection #(
    .N_APPR     (4),
    .START_APPR (2)
  ) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .emergency (emergency),
    .out       (out2),
    .active    (act2),
    .allstop   (as2),
    .state_dbg (dbg2)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench still running at %0t, required to finish earlier", $time);
    $fatal(1, "timeout");
  end

  // Expected light vector: only the served approach (if lit) differs from red.
  function automatic logic [15:0] make_out(input int n, input int appr,
                                           input logic [3:0] code, input bit lit);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < n; i++) begin
      v[4*i +: 4] = (lit && i == appr) ? code : C_RED;
    end
    return v;
  endfunction

  task automatic add_phase(input int cyc, input int n, input int appr,
                           input logic [3:0] code, input bit lit,
                           input bit as_, input bit em);
    vec_t v;
    for (int c = 0; c < cyc; c++) begin
      v.em  = em;
      v.out = make_out(n, appr, code, lit);
      v.act = 3'(appr);
      v.as  = as_;
      tbl.push_back(v);
    end
  endtask

  // One complete uninterrupted service of an approach, ending with its CLEAR.
  task automatic add_service(input int n, input int appr);
    add_phase(T_L, n, appr, C_LEFT,   1, 0, 0);
    add_phase(10,  n, appr, C_GREEN,  1, 0, 0);
    add_phase(3,   n, appr, C_YELLOW, 1, 0, 0);
    add_phase(1,   n, appr, C_RED,    0, 0, 0);
  endtask

  task automatic compare(input string name, input int idx,
                         input logic [15:0] ao, input logic [2:0] aa, input logic as_,
                         input logic [15:0] eo, input logic [2:0] ea, input logic es);
    n_checks++;
    if (ao !== eo || aa !== ea || as_ !== es) begin
      n_err++;
      $display("FAIL %s[%0d]: out=%h active=%0d allstop=%b, required out=%h active=%0d allstop=%b",
               name, idx, ao, aa, as_, eo, ea, es);
    end
  endtask

  task automatic check_reset_pattern(input string name);
    compare({name, "_d1"}, 0, {8'h00, out1}, {2'b00, act1}, as1,
            make_out(2, 0, C_FIRST, 1), 3'd0, 1'b0);
    compare({name, "_d2"}, 0, out2, {1'b0, act2}, as2,
            make_out(4, 2, C_FIRST, 1), 3'd2, 1'b0);
  endtask

  // Driver: check the current cycle, drive that row's emergency, step one cycle.
  task automatic run_table(input string name, input bit use2);
    for (int i = 0; i < tbl.size(); i++) begin
      if (use2) compare(name, i, out2, {1'b0, act2}, as2, tbl[i].out, tbl[i].act, tbl[i].as);
      else      compare(name, i, {8'h00, out1}, {2'b00, act1}, as1, tbl[i].out, tbl[i].act, tbl[i].as);
      emergency = tbl[i].em;
      @(negedge clk);
    end
    emergency = 1'b0;
    tbl.delete();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    emergency = 1'b0;
    @(negedge clk);
    check_reset_pattern("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    emergency = 1'b0;

    // Plain rotation: 0, 1, back to 0.
    do_reset();
    add_service(2, 0);
    add_service(2, 1);
    add_phase(2, 2, 0, C_FIRST, 1, 0, 0);
    run_table("rotation", 0);

    // One-cycle pulse at GREEN count 4.
    do_reset();
    add_phase(T_L, 2, 0, C_LEFT,   1, 0, 0);
    add_phase(4,   2, 0, C_GREEN,  1, 0, 0);
    add_phase(1,   2, 0, C_GREEN,  1, 0, 1);
    add_phase(3,   2, 0, C_YELLOW, 1, 0, 0);
    add_phase(4,   2, 0, C_RED,    0, 1, 0);
    add_phase(1,   2, 0, C_RED,    0, 0, 0);
    add_phase(2,   2, 1, C_FIRST,  1, 0, 0);
    run_table("pulse_green", 0);

    // Emergency held for 20 samples from YELLOW count 1.
    do_reset();
    add_phase(T_L, 2, 0, C_LEFT,   1, 0, 0);
    add_phase(10,  2, 0, C_GREEN,  1, 0, 0);
    add_phase(1,   2, 0, C_YELLOW, 1, 0, 0);
    add_phase(2,   2, 0, C_YELLOW, 1, 0, 1);
    add_phase(18,  2, 0, C_RED,    0, 1, 1);
    add_phase(1,   2, 0, C_RED,    0, 1, 0);
    add_phase(1,   2, 0, C_RED,    0, 0, 0);
    add_phase(2,   2, 1, C_FIRST,  1, 0, 0);
    run_table("held_yellow", 0);

    // One-cycle pulse at YELLOW count 1: the request must be remembered.
    do_reset();
    add_phase(T_L, 2, 0, C_LEFT,   1, 0, 0);
    add_phase(10,  2, 0, C_GREEN,  1, 0, 0);
    add_phase(1,   2, 0, C_YELLOW, 1, 0, 0);
    add_phase(1,   2, 0, C_YELLOW, 1, 0, 1);
    add_phase(1,   2, 0, C_YELLOW, 1, 0, 0);
    add_phase(4,   2, 0, C_RED,    0, 1, 0);
    add_phase(1,   2, 0, C_RED,    0, 0, 0);
    add_phase(2,   2, 1, C_FIRST,  1, 0, 0);
    run_table("pulse_yellow", 0);

    // Emergency during CLEAR, then again during the post-ALLSTOP CLEAR.
    do_reset();
    add_phase(T_L, 2, 0, C_LEFT,   1, 0, 0);
    add_phase(10,  2, 0, C_GREEN,  1, 0, 0);
    add_phase(3,   2, 0, C_YELLOW, 1, 0, 0);
    add_phase(1,   2, 0, C_RED,    0, 0, 1);
    add_phase(4,   2, 0, C_RED,    0, 1, 0);
    add_phase(1,   2, 0, C_RED,    0, 0, 1);
    add_phase(4,   2, 0, C_RED,    0, 1, 0);
    add_phase(1,   2, 0, C_RED,    0, 0, 0);
    add_phase(2,   2, 1, C_FIRST,  1, 0, 0);
    run_table("clear_emerg", 0);

    // Asynchronous reset at GREEN count 7, then a full-length first phase.
    do_reset();
    add_phase(T_L, 2, 0, C_LEFT,  1, 0, 0);
    add_phase(7,   2, 0, C_GREEN, 1, 0, 0);
    run_table("pre_reset", 0);
    #2 rst_n = 1'b0;
    #1 check_reset_pattern("async_reset");
    @(negedge clk);
    check_reset_pattern("reset_held");
    rst_n = 1'b1;
    add_service(2, 0);
    add_phase(1, 2, 1, C_FIRST, 1, 0, 0);
    run_table("post_reset", 0);

    // Four approaches starting at 2: order 2, 3, 0, 1, then 2 again.
    do_reset();
    add_service(4, 2);
    add_service(4, 3);
    add_service(4, 0);
    add_service(4, 1);
    add_phase(2, 4, 2, C_FIRST, 1, 0, 0);
    run_table("four_appr", 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
